// File: rtl/lcd_hex_display_n.sv
// HD44780 character LCD driver: power-up wait, init, busy polling, hex rendering of a ROWS x COLS snapshot.
// Each bus access is TAS+EPW+TH cycles; every write is followed by status polls until BF=0 or TIMEOUT polls.
module lcd_hex_display_n #(
    parameter int ROWS    = 2,
    parameter int COLS    = 16,
    parameter int TAS     = 2,
    parameter int EPW     = 12,
    parameter int TH      = 12,
    parameter int PWRUP   = 750000,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ROWS*COLS*4-1:0]   data_i,
    input  logic [ROWS*COLS-1:0]     mask_i,
    input  logic                     go_i,
    output logic                     busy_o,
    output logic                     err_o,
    output logic                     lcd_rs_o,
    output logic                     lcd_rw_o,
    output logic                     lcd_e_o,
    inout  wire  [7:0]               lcd_db_io
);

    localparam int N    = ROWS * COLS;
    localparam int TMAX = (TAS > EPW) ? ((TAS > TH) ? TAS : TH) : ((EPW > TH) ? EPW : TH);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(PWRUP + 1);
    localparam int QW   = $clog2(TIMEOUT + 1);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = $clog2(COLS);

    localparam logic [TW-1:0] TAS_LAST  = TW'(TAS - 1);
    localparam logic [TW-1:0] EPW_LAST  = TW'(EPW - 1);
    localparam logic [TW-1:0] TH_LAST   = TW'(TH - 1);
    localparam logic [PW-1:0] PWR_LAST  = PW'(PWRUP - 1);
    localparam logic [QW-1:0] POLL_LAST = QW'(TIMEOUT - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, ROW_ADDR, CHAR} state_t;
    typedef enum logic [1:0] {PH_S = 2'b00, PH_E = 2'b01, PH_H = 2'b10} phase_t;

    state_t          state, state_nxt;
    phase_t          phase;
    logic [TW-1:0]   tcnt;
    logic [PW-1:0]   pwr_cnt;
    logic [QW-1:0]   poll_cnt;
    logic [1:0]      init_idx;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [N*4-1:0]  shd_data;
    logic [N-1:0]    shd_mask;
    logic            rd_q, rs_q, rw_q, bf_q, err_q;
    logic [7:0]      db_q;

    logic            bus_act, tr_last, wr_done, rd_done, poll_last, step_done, pwr_done;
    logic            start_wr, wr_rs;
    logic [7:0]      wr_byte, char_byte;
    logic [3:0]      nib;
    logic            show;
    int              k;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Rows 2/3 continue rows 0/1 in DDRAM on 4-line panels.
    function automatic logic [7:0] row_cmd(input int r);
        logic [7:0] a;
        case (r)
            0:       a = 8'h00;
            1:       a = 8'h40;
            2:       a = 8'(COLS);
            default: a = 8'h40 + 8'(COLS);
        endcase
        return 8'h80 | a;
    endfunction

    assign bus_act   = (state == INIT) || (state == ROW_ADDR) || (state == CHAR);
    assign tr_last   = bus_act && (phase == PH_H) && (tcnt == TH_LAST);
    assign wr_done   = tr_last && !rd_q;
    assign rd_done   = tr_last && rd_q;
    assign poll_last = (poll_cnt == POLL_LAST);
    assign step_done = rd_done && (!bf_q || poll_last);
    assign pwr_done  = (state == PWR_WAIT) && (pwr_cnt == PWR_LAST);

    // In CHAR the next write is the following column; in ROW_ADDR it is column 0 of the current row.
    always_comb begin
        k = int'(row) * COLS + int'(col) + ((state == CHAR) ? 1 : 0);
        if (k > N - 1)
            k = N - 1;
        nib  = 4'(shd_data >> (4 * (N - 1 - k)));
        show = 1'(shd_mask >> (N - 1 - k));
        if (!show)
            char_byte = 8'h20;
        else if (nib < 4'd10)
            char_byte = 8'h30 + {4'h0, nib};
        else
            char_byte = 8'h57 + {4'h0, nib};
    end

    always_comb begin
        state_nxt = state;
        start_wr  = 1'b0;
        wr_rs     = 1'b0;
        wr_byte   = 8'h00;
        case (state)
            PWR_WAIT: if (pwr_done) begin
                state_nxt = INIT;
                start_wr  = 1'b1;
                wr_byte   = init_cmd(2'd0);
            end
            INIT: if (step_done) begin
                if (init_idx == 2'd3) begin
                    state_nxt = IDLE;
                end else begin
                    start_wr = 1'b1;
                    wr_byte  = init_cmd(init_idx + 2'd1);
                end
            end
            IDLE: if (go_i) begin
                state_nxt = ROW_ADDR;
                start_wr  = 1'b1;
                wr_byte   = row_cmd(0);
            end
            ROW_ADDR: if (step_done) begin
                state_nxt = CHAR;
                start_wr  = 1'b1;
                wr_rs     = 1'b1;
                wr_byte   = char_byte;
            end
            CHAR: if (step_done) begin
                if (col != COL_LAST) begin
                    start_wr = 1'b1;
                    wr_rs    = 1'b1;
                    wr_byte  = char_byte;
                end else if (row != ROW_LAST) begin
                    state_nxt = ROW_ADDR;
                    start_wr  = 1'b1;
                    wr_byte   = row_cmd(int'(row) + 1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= PWR_WAIT;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= PH_S;
            tcnt     <= '0;
            pwr_cnt  <= '0;
            poll_cnt <= '0;
            init_idx <= '0;
            row      <= '0;
            col      <= '0;
            shd_data <= '0;
            shd_mask <= '0;
            rd_q     <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b1;
            bf_q     <= 1'b0;
            err_q    <= 1'b0;
            db_q     <= 8'h00;
        end else begin
            if (state == PWR_WAIT && !pwr_done)
                pwr_cnt <= pwr_cnt + PW'(1);
            if (state == IDLE && go_i) begin
                shd_data <= data_i;
                shd_mask <= mask_i;
                row      <= '0;
                col      <= '0;
            end
            if (rd_done && bf_q && poll_last)
                err_q <= 1'b1;
            if (state == INIT && step_done && init_idx != 2'd3)
                init_idx <= init_idx + 2'd1;
            if (state == CHAR && step_done) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row != ROW_LAST)
                        row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            if (start_wr) begin
                rs_q     <= wr_rs;
                rw_q     <= 1'b0;
                db_q     <= wr_byte;
                rd_q     <= 1'b0;
                phase    <= PH_S;
                tcnt     <= '0;
                poll_cnt <= '0;
            end else if (wr_done) begin
                rs_q  <= 1'b0;
                rw_q  <= 1'b1;
                rd_q  <= 1'b1;
                phase <= PH_S;
                tcnt  <= '0;
            end else if (rd_done && !step_done) begin
                poll_cnt <= poll_cnt + QW'(1);
                phase    <= PH_S;
                tcnt     <= '0;
            end else if (step_done) begin
                rs_q  <= 1'b0;
                rw_q  <= 1'b1;
                rd_q  <= 1'b0;
                phase <= PH_S;
                tcnt  <= '0;
            end else if (bus_act) begin
                case (phase)
                    PH_S: if (tcnt == TAS_LAST) begin
                        phase <= PH_E;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                    PH_E: if (tcnt == EPW_LAST) begin
                        if (rd_q)
                            bf_q <= lcd_db_io[7];
                        phase <= PH_H;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                    PH_H:    tcnt  <= tcnt + TW'(1);
                    default: phase <= PH_S;
                endcase
            end
        end
    end

    assign busy_o    = (state != IDLE);
    assign err_o     = err_q;
    assign lcd_rs_o  = rs_q;
    assign lcd_rw_o  = rw_q;
    assign lcd_e_o   = (phase == PH_E);
    assign lcd_db_io = (!rw_q && !rst) ? db_q : 8'hzz;

endmodule

// File: tb/tb_lcd_hex_display_n.sv
// Two driver instances (2x16 and 4x20) with an LCD bus model; expected bus writes are queued at stimulus time.
module tb_lcd_hex_display_n;

    localparam int EPW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, rst_b, go_a, go_b;
    logic [127:0] data_a;
    logic [31:0]  mask_a;
    logic [319:0] data_b;
    logic [79:0]  mask_b;
    logic         busy_a, err_a, rs_a, rw_a, e_a;
    logic         busy_b, err_b, rs_b, rw_b, e_b;
    wire  [7:0]   db_a, db_b;
    logic         bf_a, bf_b;

    typedef struct packed {
        logic       rs;
        logic [7:0] b;
        logic [7:0] polls;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   errors = 0;
    int   checks = 0;
    int   prev_e[2], ehigh[2], polls[2], pend_polls[2], have_pend[2], poll_left[2], chars_seen[2];
    bit   stuck_arm[2], stuck_hold[2];

    lcd_hex_display_n #(.ROWS(2), .COLS(16), .TAS(1), .EPW(EPW), .TH(2), .PWRUP(20), .TIMEOUT(8)) u_a (
        .clk(clk), .rst(rst_a), .data_i(data_a), .mask_i(mask_a), .go_i(go_a),
        .busy_o(busy_a), .err_o(err_a), .lcd_rs_o(rs_a), .lcd_rw_o(rw_a), .lcd_e_o(e_a), .lcd_db_io(db_a));

    lcd_hex_display_n #(.ROWS(4), .COLS(20), .TAS(1), .EPW(EPW), .TH(2), .PWRUP(20), .TIMEOUT(8)) u_b (
        .clk(clk), .rst(rst_b), .data_i(data_b), .mask_i(mask_b), .go_i(go_b),
        .busy_o(busy_b), .err_o(err_b), .lcd_rs_o(rs_b), .lcd_rw_o(rw_b), .lcd_e_o(e_b), .lcd_db_io(db_b));

    // Panel model: answers status reads with BF in bit 7, released bus floats high.
    assign bf_a = stuck_hold[0] || (poll_left[0] != 0);
    assign bf_b = stuck_hold[1] || (poll_left[1] != 0);
    assign db_a = (rw_a && e_a) ? {bf_a, 7'h00} : 8'hzz;
    assign db_b = (rw_b && e_b) ? {bf_b, 7'h00} : 8'hzz;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (db_a[g]);
        pullup (db_b[g]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void push(input int i, input logic rs, input logic [7:0] b, input int p);
        exp_t x;
        x.rs    = rs;
        x.b     = b;
        x.polls = 8'(p);
        if (i == 0) qa.push_back(x);
        else        qb.push_back(x);
    endfunction

    function automatic void push_init(input int i, input bit stuck);
        push(i, 1'b0, 8'h38, 4);
        push(i, 1'b0, 8'h0C, stuck ? 8 : 4);
        push(i, 1'b0, 8'h06, stuck ? 8 : 4);
        push(i, 1'b0, 8'h01, stuck ? 8 : 4);
    endfunction

    function automatic void push_refresh(input int i, input logic [319:0] d, input logic [79:0] m,
                                         input int rows, input int cols, input int p);
        string      hx = "0123456789abcdef";
        int         n  = rows * cols;
        logic [3:0] nib;
        logic [7:0] addr;
        for (int r = 0; r < rows; r++) begin
            addr = (r == 0) ? 8'h00 : (r == 1) ? 8'h40 : (r == 2) ? 8'(cols) : 8'(8'h40 + cols);
            push(i, 1'b0, 8'h80 | addr, p);
            for (int c = 0; c < cols; c++) begin
                nib = d[(n - 1 - (r * cols + c)) * 4 +: 4];
                push(i, 1'b1, m[n - 1 - (r * cols + c)] ? hx[int'(nib)] : 8'h20, p);
            end
        end
    endfunction

    task automatic mon(input int i, input logic r, input logic e, input logic rw,
                       input logic rs, input logic [7:0] db);
        exp_t x;
        bit   have;
        if (r) begin
            prev_e[i] = 0; ehigh[i] = 0; polls[i] = 0; have_pend[i] = 0;
            poll_left[i] = 0; stuck_hold[i] = 0;
            return;
        end
        if (e) begin
            ehigh[i]++;
        end else if (prev_e[i] != 0) begin
            chk($sformatf("e_width%0d", i), ehigh[i], EPW);
            if (!rw) begin
                if (have_pend[i] != 0)
                    chk($sformatf("polls%0d", i), polls[i], pend_polls[i]);
                have = (i == 0) ? (qa.size() != 0) : (qb.size() != 0);
                chk($sformatf("write_expected%0d", i), have, 1);
                if (have) begin
                    x = (i == 0) ? qa.pop_front() : qb.pop_front();
                    chk($sformatf("write%0d", i), {rs, db}, {x.rs, x.b});
                    pend_polls[i] = int'(x.polls);
                    have_pend[i]  = 1;
                end
                polls[i]     = 0;
                poll_left[i] = 3;
                if (rs) chars_seen[i]++;
                if (stuck_arm[i] && !rs && db == 8'h0C) stuck_hold[i] = 1;
            end else begin
                polls[i]++;
                if (poll_left[i] > 0) poll_left[i]--;
            end
            ehigh[i] = 0;
        end
        prev_e[i] = int'(e);
    endtask

    always @(negedge clk) mon(0, rst_a, e_a, rw_a, rs_a, db_a);
    always @(negedge clk) mon(1, rst_b, e_b, rw_b, rs_b, db_b);

    task automatic wait_idle(input int i, input int budget);
        int n = 0;
        while (n < budget && ((i == 0) ? busy_a : busy_b)) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("busy_low%0d", i), (i == 0) ? busy_a : busy_b, 0);
        chk($sformatf("drained%0d", i), (i == 0) ? qa.size() : qb.size(), 0);
        chk($sformatf("last_polls%0d", i), polls[i], pend_polls[i]);
    endtask

    task automatic no_e_window(input string tag);
        bit saw = 0;
        repeat (20) begin
            @(negedge clk);
            if (e_a) saw = 1;
        end
        chk(tag, saw, 0);
    endtask

    task automatic pulse_go_a();
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        chk("busy_after_go", busy_a, 1);
    endtask

    initial begin
        int base;
        int n;
        rst_a = 1'b1; rst_b = 1'b1; go_a = 1'b0; go_b = 1'b0;
        data_a = '0; mask_a = '0; data_b = '0; mask_b = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", busy_a, 1);
        chk("rst_err", err_a, 0);
        chk("rst_rs", rs_a, 0);
        chk("rst_rw", rw_a, 1);
        chk("rst_e", e_a, 0);
        chk("rst_db_released", db_a, 8'hFF);

        push_init(0, 1'b0);
        rst_a = 1'b0;
        no_e_window("pwrup_no_e");
        wait_idle(0, 2000);
        chk("init_err", err_a, 0);

        data_a = 128'h0123456789ABCDEF_FEDCBA9876543210;
        mask_a = '1;
        push_refresh(0, {192'h0, data_a}, {48'h0, mask_a}, 2, 16, 4);
        pulse_go_a();
        repeat (50) @(negedge clk);
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        wait_idle(0, 5000);

        data_a = 128'h0123456789ABCDEF_FEDCBA9876543210 ^ 128'h5A;
        mask_a = {16'h8001, 16'h0000};
        push_refresh(0, {192'h0, data_a}, {48'h0, mask_a}, 2, 16, 4);
        pulse_go_a();
        data_a = ~data_a;
        mask_a = '1;
        wait_idle(0, 5000);

        data_a = {$urandom, $urandom, $urandom, $urandom};
        mask_a = '1;
        push_refresh(0, {192'h0, data_a}, {48'h0, mask_a}, 2, 16, 4);
        base = chars_seen[0];
        pulse_go_a();
        n = 0;
        while (n < 3000 && !(chars_seen[0] >= base + 5 && e_a && rs_a && !rw_a)) begin
            @(negedge clk);
            n++;
        end
        chk("char_e_found", e_a && rs_a && !rw_a, 1);
        rst_a = 1'b1;
        #1;
        chk("midrst_e", e_a, 0);
        chk("midrst_rw", rw_a, 1);
        chk("midrst_db_released", db_a, 8'hFF);
        chk("midrst_busy", busy_a, 1);
        @(negedge clk);
        qa.delete();
        stuck_arm[0] = 1'b1;
        push_init(0, 1'b1);
        rst_a = 1'b0;
        no_e_window("repwrup_no_e");
        wait_idle(0, 3000);
        chk("timeout_err", err_a, 1);

        data_a = {$urandom, $urandom, $urandom, $urandom};
        mask_a = {$urandom};
        push_refresh(0, {192'h0, data_a}, {48'h0, mask_a}, 2, 16, 8);
        pulse_go_a();
        wait_idle(0, 8000);
        chk("err_sticky", err_a, 1);

        push_init(1, 1'b0);
        rst_b = 1'b0;
        wait_idle(1, 2000);
        for (int w = 0; w < 10; w++) data_b[w*32 +: 32] = $urandom;
        mask_b = {$urandom, $urandom, $urandom};
        base = chars_seen[1];
        push_refresh(1, data_b, mask_b, 4, 20, 4);
        go_b = 1'b1;
        @(negedge clk);
        go_b = 1'b0;
        wait_idle(1, 8000);
        chk("b_char_writes", chars_seen[1] - base, 80);
        chk("b_err", err_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_hex_display_n.md
Name: lcd_hex_display_n

Overview:
- Parametrised HD44780-class character LCD driver for on-board debug display of hex register contents (ROWS x COLS characters).
- Owns the power-up delay, the init sequence, busy-flag polling with timeout, and real E-pulse timing instead of tying E to clk.
- Snapshots data/mask on a go request, then renders every character as a hex digit or a blank.
- Sits between the debug/status logic and the board LCD pins.

Parameters:
- ROWS, 2, display rows, 1..4.
- COLS, 16, characters per row, 8..20.
- TAS, 2, clk cycles RS/RW/DB stable before E rises, >=1.
- EPW, 12, clk cycles E high, >=1.
- TH, 12, clk cycles after E falls before the next transaction, >=1.
- PWRUP, 750000, clk cycles waited after reset before the first bus access.
- TIMEOUT, 4096, max busy-flag polls per wait before giving up.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- data_i  in  ROWS*COLS*4  nibbles, char k=r*COLS+c at data_i[(ROWS*COLS-1-k)*4 +: 4] (MSB nibble first)
- mask_i  in  ROWS*COLS  mask_i[ROWS*COLS-1-k]=1 shows char k as hex, 0 shows space (0x20)
- go_i  in  1  refresh request, level sampled only in IDLE
- busy_o  out  1  1 while initialising or refreshing
- err_o  out  1  sticky busy-flag timeout seen
- lcd_rs_o  out  1  register select
- lcd_rw_o  out  1  1=read, 0=write
- lcd_e_o  out  1  enable strobe
- lcd_db_io  inout  8  data bus, driven only when lcd_rw_o=0

Behaviour:
- Reset (async, any state):
  - busy_o=1, err_o=0, lcd_rs_o=0, lcd_rw_o=1, lcd_e_o=0, DB released (Z).
  - All counters cleared, FSM to PWR_WAIT.
  - A mid-transaction reset must drop E in the same cycle.
- Bus transaction (write or read), TAS+EPW+TH cycles:
  - Phase S: TAS cycles with RS/RW (and DB for a write) set.
  - Phase E: EPW cycles with E=1.
  - Phase H: TH cycles with E=0.
  - RS/RW/DB are held through all three phases.
  - A read samples DB[7] (BF) on the last E-high cycle.
- Busy wait: after every write, poll with status reads (RS=0, RW=1) until BF=0.
  - If TIMEOUT polls all return BF=1: set err_o and continue as if BF=0.
  - err_o clears only on reset.
- FSM:
  - PWR_WAIT: count PWRUP cycles.
  - INIT: write 0x38, 0x0C, 0x06, 0x01, each followed by a busy wait.
  - IDLE: busy_o=0.
    - On go_i=1, capture data_i/mask_i into shadow registers in that cycle.
    - Set busy_o=1 on the next edge, then go to ROW_ADDR with r=0.
  - ROW_ADDR: write 0x80|addr(r), then busy wait. Row addresses are 0x00, 0x40, COLS, 0x40+COLS.
  - CHAR: write data char k (RS=1), then busy wait; c++.
    - If c==COLS-1: r++, c=0, go to ROW_ADDR.
    - If r==ROWS-1 as well: go to IDLE.
- go_i outside IDLE is ignored; changes to data_i during a refresh do not affect the display.
- Hex conversion: nibble 0-9 -> 0x30+n; nibble A-F -> 0x57+n (lowercase a-f); masked-off char -> 0x20.
- Bus drive: DB output-enabled iff lcd_rw_o=0 and the FSM is not in reset. Address and index counters are sized $clog2 and do not wrap.
- Total refresh = ROWS*(COLS+1) writes plus polls. busy_o returns to 0 one cycle after the last busy wait completes.

Test Plan:
- Bench parameters: PWRUP=20, TAS=1, EPW=2, TH=2, TIMEOUT=8, ROWS=2, COLS=16. LCD BFM returns BF=1 for 3 polls after each write.
- Init:
  - Release rst -> no E pulse for 20 cycles.
  - Writes 0x38, 0x0C, 0x06, 0x01 with RS=0, 4 polls each, then busy_o=0, err_o=0.
  - E high exactly 2 cycles per access.
- Refresh:
  - data_i=0x0123456789ABCDEF_FEDCBA9876543210, mask all 1, go_i pulse.
  - Expect 0x80, then "0123456789abcdef", then 0xC0, then "fedcba9876543210"; busy_o then returns to 0.
- Mask and snapshot:
  - mask_i row0=0x8001, row1=0; data_i changes during refresh.
  - Expect row0 = first and last char as captured hex, 14 spaces between; row1 = 16 x 0x20; the data change is ignored.
- Timeout: BFM holds BF=1 forever after the 0x0C write -> exactly 8 polls, err_o=1, FSM proceeds with 0x06, and err_o stays 1 through later refreshes.
- 4x20: ROWS=4, COLS=20 -> address commands 0x80, 0xC0, 0x94, 0xD4 and 80 char writes.
- Reset mid-CHAR write: assert rst while E=1 -> E=0, DB=Z, RW=1 in the same cycle, and the full PWR_WAIT/INIT sequence repeats.
